// File: rtl/line_fetch_cntrl.sv
// rtl/line_fetch_cntrl.sv - frame buffer row fetcher with ping-pong line buffer and pixel streamer
// Optional REQ watchdog: define LINE_FETCH_TIMEOUT_EN.
module line_fetch_cntrl #(
    parameter int FBUFF_ADDR_WIDTH = 12,
    parameter int FBUFF_WIDTH      = 60,
    parameter int FBUFF_DEPTH      = 3840,
    parameter int PXL_WIDTH        = 3,
    parameter int WORDS_PER_LINE   = 32,
    parameter int ROW_WIDTH        = 7
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        fetch_start_i,
    input  logic [ROW_WIDTH-1:0]        fetch_row_i,
    output logic                        fetch_busy_o,
    output logic                        fetch_done_o,
    output logic                        fetch_err_o,
    output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
    output logic                        fbuff_en_o,
    output logic                        fbuff_rd_req_o,
    input  logic                        fbuff_rd_rsp_i,
    input  logic [FBUFF_WIDTH-1:0]      fbuff_data_i,
    input  logic                        pxl_rd_i,
    output logic [PXL_WIDTH-1:0]        pxl_o,
    output logic                        pxl_vld_o
);

    localparam int PXL_PER_WORD = FBUFF_WIDTH / PXL_WIDTH;
    localparam int NUM_ROWS     = FBUFF_DEPTH / WORDS_PER_LINE;
    localparam int WIDX_W       = $clog2(WORDS_PER_LINE);
    localparam int PIDX_W       = $clog2(PXL_PER_WORD);

    localparam logic [WIDX_W-1:0]    WLAST    = WIDX_W'(WORDS_PER_LINE - 1);
    localparam logic [PIDX_W-1:0]    PLAST    = PIDX_W'(PXL_PER_WORD - 1);
    localparam logic [ROW_WIDTH:0]   ROWS_LIM = (ROW_WIDTH+1)'(NUM_ROWS);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t                      state, state_nxt;
    logic [WIDX_W-1:0]           word_idx, idx_nxt;
    logic [FBUFF_ADDR_WIDTH-1:0] base, base_nxt;
    logic                        wr_bank, bank_nxt;
    logic                        start_ok, err_nxt, done_nxt;
    logic                        row_ok;

    logic [FBUFF_WIDTH-1:0]      line_buf [2][WORDS_PER_LINE];

    assign row_ok = ({1'b0, fetch_row_i} < ROWS_LIM);

`ifdef LINE_FETCH_TIMEOUT_EN
    logic [3:0] wd_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wd_cnt <= '0;
        end else if (state == REQ) begin
            wd_cnt <= wd_cnt + 4'd1;
        end else begin
            wd_cnt <= '0;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = word_idx;
        base_nxt  = base;
        bank_nxt  = wr_bank;
        start_ok  = 1'b0;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_start_i) begin
                    if (row_ok) begin
                        start_ok  = 1'b1;
                        base_nxt  = FBUFF_ADDR_WIDTH'(fetch_row_i) * FBUFF_ADDR_WIDTH'(WORDS_PER_LINE);
                        idx_nxt   = '0;
                        bank_nxt  = ~wr_bank;
                        state_nxt = REQ;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            REQ: begin
                err_nxt = fetch_start_i;
                if (fbuff_rd_rsp_i) begin
                    // done is raised here so that it is visible during the final GAP cycle
                    state_nxt = GAP;
                    done_nxt  = (word_idx == WLAST);
                end
`ifdef LINE_FETCH_TIMEOUT_EN
                else if (wd_cnt == 4'd14) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
`endif
            end
            GAP: begin
                err_nxt = fetch_start_i;
                if (word_idx == WLAST) begin
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = word_idx + 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state itself
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state          <= IDLE;
            word_idx       <= '0;
            base           <= '0;
            wr_bank        <= 1'b0;
            fetch_busy_o   <= 1'b0;
            fetch_done_o   <= 1'b0;
            fetch_err_o    <= 1'b0;
            fbuff_addr_o   <= '0;
            fbuff_en_o     <= 1'b0;
            fbuff_rd_req_o <= 1'b0;
        end else begin
            state          <= state_nxt;
            word_idx       <= idx_nxt;
            base           <= base_nxt;
            wr_bank        <= bank_nxt;
            fetch_busy_o   <= (state_nxt != IDLE);
            fetch_done_o   <= done_nxt;
            fetch_err_o    <= err_nxt;
            fbuff_addr_o   <= base_nxt + FBUFF_ADDR_WIDTH'(idx_nxt);
            fbuff_en_o     <= (state_nxt == REQ);
            fbuff_rd_req_o <= (state_nxt == REQ);
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == REQ && fbuff_rd_rsp_i) begin
            line_buf[wr_bank][word_idx] <= fbuff_data_i;
        end
    end

    logic [WIDX_W-1:0]      ptr_w;
    logic [PIDX_W-1:0]      ptr_p;
    logic                   ptr_end;
    logic [FBUFF_WIDTH-1:0] rd_word;
    logic [PXL_WIDTH-1:0]   rd_pxl;

    assign rd_word = line_buf[~wr_bank][ptr_w];
    assign rd_pxl  = PXL_WIDTH'(rd_word >> (ptr_p * PXL_WIDTH));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_w     <= '0;
            ptr_p     <= '0;
            ptr_end   <= 1'b0;
            pxl_o     <= '0;
            pxl_vld_o <= 1'b0;
        end else if (start_ok) begin
            ptr_w     <= '0;
            ptr_p     <= '0;
            ptr_end   <= 1'b0;
            pxl_vld_o <= 1'b0;
        end else if (pxl_rd_i) begin
            if (ptr_end) begin
                pxl_o     <= '0;
                pxl_vld_o <= 1'b0;
            end else begin
                pxl_o     <= rd_pxl;
                pxl_vld_o <= 1'b1;
                if (ptr_p == PLAST) begin
                    ptr_p <= '0;
                    if (ptr_w == WLAST) begin
                        ptr_end <= 1'b1;
                    end else begin
                        ptr_w <= ptr_w + 1'b1;
                    end
                end else begin
                    ptr_p <= ptr_p + 1'b1;
                end
            end
        end else begin
            pxl_vld_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_fetch_cntrl.sv
// tb/tb_line_fetch_cntrl.sv - self-checking bench for line_fetch_cntrl with frame buffer responder model
module tb_line_fetch_cntrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fetch_start = 1'b0;
    logic [6:0]  fetch_row = '0;
    logic        busy, done, err;
    logic [11:0] addr;
    logic        en, req;
    logic        rsp = 1'b0;
    logic [59:0] data = '0;
    logic        pxl_rd = 1'b0;
    logic [2:0]  pxl;
    logic        vld;

    int checks = 0;
    int errors = 0;

    logic [59:0] fb_mem [3840];
    int rsp_cnt = 0;
    bit never_rsp = 1'b0;

    // Reference model: which row each bank holds (-1 = unknown) and the write bank
    int m_row [2];
    int m_wr;

    line_fetch_cntrl dut (
        .clk_i(clk), .rstn_i(rstn),
        .fetch_start_i(fetch_start), .fetch_row_i(fetch_row),
        .fetch_busy_o(busy), .fetch_done_o(done), .fetch_err_o(err),
        .fbuff_addr_o(addr), .fbuff_en_o(en), .fbuff_rd_req_o(req),
        .fbuff_rd_rsp_i(rsp), .fbuff_data_i(data),
        .pxl_rd_i(pxl_rd), .pxl_o(pxl), .pxl_vld_o(vld)
    );

    always #5 clk = ~clk;

    // Responder: req seen in cycle N -> rsp valid during cycle N+2, then back to idle
    always @(negedge clk) begin
        if (!rstn) begin
            rsp = 1'b0;
            rsp_cnt = 0;
        end else if (rsp) begin
            rsp = 1'b0;
            rsp_cnt = 0;
            data = 60'({$urandom(), $urandom()});
        end else if (req && !never_rsp) begin
            rsp_cnt++;
            if (rsp_cnt == 3) begin
                rsp = 1'b1;
                data = fb_mem[addr];
            end
        end
    end

    function automatic logic [2:0] exp_pix(input int row, input int n);
        logic [59:0] w;
        w = fb_mem[row * 32 + n / 20];
        return 3'(w >> (3 * (n % 20)));
    endfunction

    task automatic start_pulse(input int row, input bit rd);
        fetch_start = 1'b1;
        fetch_row = 7'(row);
        pxl_rd = rd;
        @(negedge clk);
        fetch_start = 1'b0;
        pxl_rd = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit seen);
        seen = 1'b0;
        cyc = 0;
        for (int c = 1; c <= budget; c++) begin
            if (done) begin
                seen = 1'b1;
                cyc = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, addr, en, req, pxl, vld} !== 20'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {busy, done, err, addr, en, req, pxl, vld});
        end
        rstn = 1'b1;
        m_wr = 0;
        m_row[0] = -1;
        m_row[1] = -1;
        @(negedge clk);
    endtask

    task automatic test_row0;
        int k;
        bit prev_req, seen;
        k = 0;
        prev_req = 1'b0;
        seen = 1'b0;
        start_pulse(0, 1'b0);
        m_wr ^= 1;
        for (int c = 1; c <= 200 && !seen; c++) begin
            if (req && !prev_req) begin
                checks++;
                if (addr !== 12'(k) || c != 1 + 4 * k) begin
                    errors++;
                    $display("FAIL row0_req got addr %0d cyc %0d exp addr %0d cyc %0d", addr, c, k, 1 + 4 * k);
                end
                k++;
            end
            if (done) begin
                seen = 1'b1;
                checks++;
                if (c != 128 || k != 32) begin
                    errors++;
                    $display("FAIL row0_done got cyc %0d words %0d exp cyc 128 words 32", c, k);
                end
            end
            prev_req = req;
            if (!seen) @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL row0_timeout got no done exp done");
        end
        m_row[m_wr] = 0;
        @(negedge clk);
    endtask

    task automatic test_pixels;
        int cyc, gap, rrow;
        bit seen, ok;
        logic [2:0] last, e;
        start_pulse(3, 1'b0);
        m_wr ^= 1;
        wait_done(200, cyc, seen);
        checks++;
        if (!seen || cyc != 128) begin
            errors++;
            $display("FAIL row3_done got seen %0d cyc %0d exp seen 1 cyc 128", seen, cyc);
        end
        m_row[m_wr] = 3;
        start_pulse(4, 1'b0);
        m_wr ^= 1;
        rrow = m_row[m_wr ^ 1];
        last = '0;
        for (int n = 0; n < 640; n++) begin
            gap = (n == 0) ? 0 : int'($urandom_range(0, 2));
            repeat (gap) begin
                pxl_rd = 1'b0;
                @(negedge clk);
                checks++;
                if (vld !== 1'b0 || pxl !== last) begin
                    errors++;
                    $display("FAIL pix_hold got vld %0b pxl %0d exp vld 0 pxl %0d", vld, pxl, last);
                end
            end
            pxl_rd = 1'b1;
            @(negedge clk);
            e = exp_pix(rrow, n);
            checks++;
            if (vld !== 1'b1 || pxl !== e) begin
                errors++;
                $display("FAIL pix_%0d got vld %0b pxl %0d exp vld 1 pxl %0d", n, vld, pxl, e);
            end
            last = e;
        end
        @(negedge clk);
        pxl_rd = 1'b0;
        checks++;
        if (vld !== 1'b0 || pxl !== 3'd0) begin
            errors++;
            $display("FAIL pix_past_end got vld %0b pxl %0d exp vld 0 pxl 0", vld, pxl);
        end
        wait_idle(300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL row4_idle got busy exp idle");
        end
        m_row[m_wr] = 4;
    endtask

    task automatic test_errors;
        int cyc, rrow;
        bit seen, ok;
        logic [2:0] e;
        seen = 1'b0;
        start_pulse(7, 1'b0);
        m_wr ^= 1;
        for (int c = 1; c <= 200 && !seen; c++) begin
            if (c == 20) begin
                fetch_start = 1'b1;
                fetch_row = 7'd2;
            end
            if (c == 21) begin
                fetch_start = 1'b0;
                checks++;
                if (err !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_drop got err %0b busy %0b exp err 1 busy 1", err, busy);
                end
            end
            if (done) begin
                seen = 1'b1;
                checks++;
                if (c != 128) begin
                    errors++;
                    $display("FAIL row7_done got cyc %0d exp 128", c);
                end
            end
            if (!seen) @(negedge clk);
        end
        @(negedge clk);
        m_row[m_wr] = 7;
        start_pulse(8, 1'b0);
        m_wr ^= 1;
        rrow = m_row[m_wr ^ 1];
        for (int n = 0; n < 40; n++) begin
            pxl_rd = 1'b1;
            @(negedge clk);
            e = exp_pix(rrow, n);
            checks++;
            if (vld !== 1'b1 || pxl !== e) begin
                errors++;
                $display("FAIL nosw_busy_pix_%0d got %0d exp %0d", n, pxl, e);
            end
        end
        pxl_rd = 1'b0;
        wait_idle(200, ok);
        m_row[m_wr] = 8;
        start_pulse(120, 1'b0);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || req !== 1'b0) begin
            errors++;
            $display("FAIL row_range got err %0b busy %0b req %0b exp err 1 busy 0 req 0", err, busy, req);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse got err %0b busy %0b exp 0 0", err, busy);
        end
        start_pulse(10, 1'b0);
        m_wr ^= 1;
        rrow = m_row[m_wr ^ 1];
        for (int n = 0; n < 25; n++) begin
            pxl_rd = 1'b1;
            @(negedge clk);
            e = exp_pix(rrow, n);
            checks++;
            if (vld !== 1'b1 || pxl !== e) begin
                errors++;
                $display("FAIL nosw_idle_pix_%0d got %0d exp %0d", n, pxl, e);
            end
        end
        pxl_rd = 1'b0;
        wait_idle(200, ok);
        m_row[m_wr] = 10;
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit seen, hit;
        hit = 1'b0;
        start_pulse(9, 1'b0);
        for (int c = 0; c < 100; c++) begin
            if (req && addr == 12'(9 * 32 + 10)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_mid_reach got no word 10 exp word 10");
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (req !== 1'b0 || en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got req %0b en %0b busy %0b exp 0 0 0", req, en, busy);
        end
        @(negedge clk);
        rstn = 1'b1;
        m_wr = 0;
        m_row[0] = -1;
        m_row[1] = -1;
        @(negedge clk);
        start_pulse(5, 1'b0);
        m_wr ^= 1;
        wait_done(200, cyc, seen);
        checks++;
        if (!seen || cyc != 128) begin
            errors++;
            $display("FAIL row5_done got seen %0d cyc %0d exp seen 1 cyc 128", seen, cyc);
        end
        m_row[m_wr] = 5;
    endtask

    task automatic test_start_with_rd;
        bit ok;
        logic [2:0] e;
        start_pulse(6, 1'b1);
        m_wr ^= 1;
        checks++;
        if (vld !== 1'b0) begin
            errors++;
            $display("FAIL start_rd_vld got %0b exp 0", vld);
        end
        pxl_rd = 1'b1;
        @(negedge clk);
        pxl_rd = 1'b0;
        e = exp_pix(m_row[m_wr ^ 1], 0);
        checks++;
        if (vld !== 1'b1 || pxl !== e) begin
            errors++;
            $display("FAIL start_rd_pix0 got vld %0b pxl %0d exp vld 1 pxl %0d", vld, pxl, e);
        end
        wait_idle(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL row6_idle got busy exp idle");
        end
        m_row[m_wr] = 6;
    endtask

`ifdef LINE_FETCH_TIMEOUT_EN
    task automatic test_timeout;
        int nreq;
        bit seen, dn;
        nreq = 0;
        seen = 1'b0;
        dn = 1'b0;
        never_rsp = 1'b1;
        start_pulse(11, 1'b0);
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (req) nreq++;
            if (done) dn = 1'b1;
            if (err) begin
                seen = 1'b1;
                checks++;
                if (c != 16 || busy !== 1'b0 || nreq != 15 || dn) begin
                    errors++;
                    $display("FAIL timeout got cyc %0d busy %0b req_cycles %0d done %0b exp 16 0 15 0", c, busy, nreq, dn);
                end
            end
            if (!seen) @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_missing got no err exp err");
        end
        never_rsp = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        logic [2:0] t;
        for (int k = 0; k < 3840; k++) begin
            fb_mem[k] = 60'({$urandom(), $urandom()});
        end
        for (int k = 96; k < 128; k++) begin
            t = 3'(k);
            fb_mem[k] = {20{t}};
        end
        @(negedge clk);
        test_reset();
        test_row0();
        test_pixels();
        test_errors();
        test_reset_mid();
        test_start_with_rd();
`ifdef LINE_FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
